// File: rtl/sim_mem_arb.sv
// Multi-port round-robin arbitrated simulation memory with fixed access latency and byte-lane writes.
// Optional per-lane even parity with error injection is enabled by defining SIM_MEM_PARITY_EN.
module sim_mem_arb #(
    parameter int SIZE    = 1024,
    parameter int WIDTH   = 36,
    parameter int NBYTES  = 4,
    parameter int NPORTS  = 2,
    parameter int LATENCY = 2,
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int BW = WIDTH / NBYTES,
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [0:NPORTS-1]             req,
    input  logic [0:NPORTS-1]             we,
    input  logic [0:NPORTS-1][0:NBYTES-1] wea,
    input  logic [0:NPORTS-1][0:AW-1]     addr,
    input  logic [0:NPORTS-1][0:WIDTH-1]  din,
    output logic [0:NPORTS-1]             ack,
    output logic [0:WIDTH-1]              dout,
    output logic                          busy,
    input  logic                          par_inject,
    output logic                          perr
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [PW-1:0]       last_q, last_d;
    logic                cap_we_q, cap_we_d;
    logic [0:NBYTES-1]   cap_wea_q, cap_wea_d;
    logic [0:AW-1]       cap_addr_q, cap_addr_d;
    logic [0:WIDTH-1]    cap_din_q, cap_din_d;
    logic                cap_inj_q, cap_inj_d;
    logic [0:WIDTH-1]    dout_q, dout_d;
    logic                perr_q, perr_d;
    logic                found;
    logic                in_range, access_edge, do_write;
    logic [0:WIDTH-1]    rd_word;

    // Memory array has no reset so its contents survive a reset mid-access.
    logic [0:WIDTH-1]    mem [0:SIZE-1];

    assign in_range    = (int'(cap_addr_q) < SIZE);
    assign access_edge = (state_q == BUSY) && (cnt_q == 4'd0);
    assign do_write    = access_edge && cap_we_q && in_range;
    assign rd_word     = in_range ? mem[cap_addr_q] : '0;

`ifdef SIM_MEM_PARITY_EN
    logic [0:NBYTES-1]   pmem [0:SIZE-1];
    logic [0:NBYTES-1]   rd_par, calc_par;

    assign rd_par = in_range ? pmem[cap_addr_q] : '0;

    always_comb begin
        calc_par = '0;
        for (int l = 0; l < NBYTES; l++) calc_par[l] = ^rd_word[l*BW +: BW];
    end
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cap_we_d   = cap_we_q;
        cap_wea_d  = cap_wea_q;
        cap_addr_d = cap_addr_q;
        cap_din_d  = cap_din_q;
        cap_inj_d  = cap_inj_q;
        dout_d     = dout_q;
        perr_d     = 1'b0;
        found      = 1'b0;
        case (state_q)
            IDLE: begin
                // Search begins just past the previous winner.
                for (int i = 1; i <= NPORTS; i++) begin
                    if (!found && req[(int'(last_q) + i) % NPORTS]) begin
                        found   = 1'b1;
                        grant_d = PW'((int'(last_q) + i) % NPORTS);
                    end
                end
                if (found) begin
                    last_d     = grant_d;
                    cap_we_d   = we[grant_d];
                    cap_wea_d  = wea[grant_d];
                    cap_addr_d = addr[grant_d];
                    cap_din_d  = din[grant_d];
                    cap_inj_d  = par_inject;
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!cap_we_q) begin
                        dout_d = rd_word;
`ifdef SIM_MEM_PARITY_EN
                        perr_d = in_range && (|(calc_par ^ rd_par));
`endif
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            last_q     <= PW'(NPORTS - 1);
            cap_we_q   <= 1'b0;
            cap_wea_q  <= '0;
            cap_addr_q <= '0;
            cap_din_q  <= '0;
            cap_inj_q  <= 1'b0;
            dout_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cap_we_q   <= cap_we_d;
            cap_wea_q  <= cap_wea_d;
            cap_addr_q <= cap_addr_d;
            cap_din_q  <= cap_din_d;
            cap_inj_q  <= cap_inj_d;
            dout_q     <= dout_d;
            perr_q     <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            for (int l = 0; l < NBYTES; l++) begin
                if (cap_wea_q[l]) begin
                    mem[cap_addr_q][l*BW +: BW] <= cap_din_q[l*BW +: BW];
`ifdef SIM_MEM_PARITY_EN
                    pmem[cap_addr_q][l] <= (^cap_din_q[l*BW +: BW]) ^ cap_inj_q;
`endif
                end
            end
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == DONE) ack[grant_q] = 1'b1;
    end

    assign dout = dout_q;
    assign busy = (state_q != IDLE);
`ifdef SIM_MEM_PARITY_EN
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule
